// File: rtl/ahb_dsram_arbiter.sv
// Two-master AHB-Lite arbiter in front of the data SRAM slave; losing transfers are held and replayed.
// Define AHB_DSRAM_ARB_RR_EN for round-robin arbitration; otherwise M0 has fixed priority.
module ahb_dsram_arbiter #(
  parameter int AW = 16
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL_M0,
  input  logic [1:0]    HTRANS_M0,
  input  logic [2:0]    HSIZE_M0,
  input  logic          HWRITE_M0,
  input  logic [AW-1:0] HADDR_M0,
  input  logic [31:0]   HWDATA_M0,
  input  logic          HREADY_M0,
  output logic          HREADYOUT_M0,
  output logic          HRESP_M0,
  output logic [31:0]   HRDATA_M0,
  input  logic          HSEL_M1,
  input  logic [1:0]    HTRANS_M1,
  input  logic [2:0]    HSIZE_M1,
  input  logic          HWRITE_M1,
  input  logic [AW-1:0] HADDR_M1,
  input  logic [31:0]   HWDATA_M1,
  input  logic          HREADY_M1,
  output logic          HREADYOUT_M1,
  output logic          HRESP_M1,
  output logic [31:0]   HRDATA_M1,
  output logic          HSEL_S,
  output logic [1:0]    HTRANS_S,
  output logic [2:0]    HSIZE_S,
  output logic          HWRITE_S,
  output logic [AW-1:0] HADDR_S,
  output logic [31:0]   HWDATA_S,
  output logic          HREADY_S,
  input  logic          HREADYOUT_SI,
  input  logic          HRESP_SI,
  input  logic [31:0]   HRDATA_SI
);

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_M0 = 2'd1, OWN_M1 = 2'd2} own_t;
  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  own_t          dp_own;
  logic          pend0, pend1;
  logic [2:0]    hold_size0, hold_size1;
  logic          hold_write0, hold_write1;
  logic [AW-1:0] hold_addr0, hold_addr1;

  logic live0, live1, cand0, cand1, gnt0, gnt1, cap0, cap1;

  // Gating with HRESETn keeps a live master off the slave bus while reset is asserted.
  assign live0 = HRESETn & HSEL_M0 & HTRANS_M0[1] & HREADY_M0;
  assign live1 = HRESETn & HSEL_M1 & HTRANS_M1[1] & HREADY_M1;
  assign cand0 = pend0 | live0;
  assign cand1 = pend1 | live1;

`ifdef AHB_DSRAM_ARB_RR_EN
  logic last_m1;

  assign gnt0 = cand0 & (~cand1 | last_m1);
  assign gnt1 = cand1 & ~gnt0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      last_m1 <= 1'b1;
    end else if (HREADYOUT_SI && (gnt0 || gnt1)) begin
      last_m1 <= gnt1;
    end
  end
`else
  assign gnt0 = cand0;
  assign gnt1 = cand1 & ~cand0;
`endif

  // A live request not issued this cycle (lost, or slave busy) goes into its hold register.
  assign cap0 = live0 & ~pend0 & ~(gnt0 & HREADYOUT_SI);
  assign cap1 = live1 & ~pend1 & ~(gnt1 & HREADYOUT_SI);

  always_comb begin
    HSEL_S   = 1'b0;
    HTRANS_S = TRANS_IDLE;
    HSIZE_S  = '0;
    HWRITE_S = 1'b0;
    HADDR_S  = '0;
    if (gnt0) begin
      HSEL_S   = 1'b1;
      HTRANS_S = pend0 ? TRANS_NONSEQ : HTRANS_M0;
      HSIZE_S  = pend0 ? hold_size0   : HSIZE_M0;
      HWRITE_S = pend0 ? hold_write0  : HWRITE_M0;
      HADDR_S  = pend0 ? hold_addr0   : HADDR_M0;
    end else if (gnt1) begin
      HSEL_S   = 1'b1;
      HTRANS_S = pend1 ? TRANS_NONSEQ : HTRANS_M1;
      HSIZE_S  = pend1 ? hold_size1   : HSIZE_M1;
      HWRITE_S = pend1 ? hold_write1  : HWRITE_M1;
      HADDR_S  = pend1 ? hold_addr1   : HADDR_M1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend0       <= 1'b0;
      pend1       <= 1'b0;
      dp_own      <= OWN_NONE;
      hold_size0  <= '0;
      hold_write0 <= 1'b0;
      hold_addr0  <= '0;
      hold_size1  <= '0;
      hold_write1 <= 1'b0;
      hold_addr1  <= '0;
    end else begin
      if (cap0) begin
        pend0       <= 1'b1;
        hold_size0  <= HSIZE_M0;
        hold_write0 <= HWRITE_M0;
        hold_addr0  <= HADDR_M0;
      end else if (pend0 && gnt0 && HREADYOUT_SI) begin
        pend0 <= 1'b0;
      end
      if (cap1) begin
        pend1       <= 1'b1;
        hold_size1  <= HSIZE_M1;
        hold_write1 <= HWRITE_M1;
        hold_addr1  <= HADDR_M1;
      end else if (pend1 && gnt1 && HREADYOUT_SI) begin
        pend1 <= 1'b0;
      end
      if (HREADYOUT_SI) begin
        dp_own <= gnt0 ? OWN_M0 : (gnt1 ? OWN_M1 : OWN_NONE);
      end
    end
  end

  // Response routing: the data-phase owner sees the slave; a pending master is stalled.
  always_comb begin
    HREADYOUT_M0 = ~pend0;
    HRESP_M0     = 1'b0;
    HRDATA_M0    = '0;
    HREADYOUT_M1 = ~pend1;
    HRESP_M1     = 1'b0;
    HRDATA_M1    = '0;
    HWDATA_S     = '0;
    case (dp_own)
      OWN_M0: begin
        HREADYOUT_M0 = HREADYOUT_SI;
        HRESP_M0     = HRESP_SI;
        HRDATA_M0    = HRDATA_SI;
        HWDATA_S     = HWDATA_M0;
      end
      OWN_M1: begin
        HREADYOUT_M1 = HREADYOUT_SI;
        HRESP_M1     = HRESP_SI;
        HRDATA_M1    = HRDATA_SI;
        HWDATA_S     = HWDATA_M1;
      end
      default: ;
    endcase
  end

  assign HREADY_S = HREADYOUT_SI;

endmodule

// File: tb/tb_ahb_dsram_arbiter.sv
// Bench for ahb_dsram_arbiter: two AHB-Lite master models, an SRAM slave model and a read-data scoreboard.
module tb_ahb_dsram_arbiter;
  localparam int AW = 16;

  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic          HRESETn;
  logic          HSEL_M0, HWRITE_M0, HREADY_M0, HREADYOUT_M0, HRESP_M0;
  logic [1:0]    HTRANS_M0;
  logic [2:0]    HSIZE_M0;
  logic [AW-1:0] HADDR_M0;
  logic [31:0]   HWDATA_M0, HRDATA_M0;
  logic          HSEL_M1, HWRITE_M1, HREADY_M1, HREADYOUT_M1, HRESP_M1;
  logic [1:0]    HTRANS_M1;
  logic [2:0]    HSIZE_M1;
  logic [AW-1:0] HADDR_M1;
  logic [31:0]   HWDATA_M1, HRDATA_M1;
  logic          HSEL_S, HWRITE_S, HREADY_S, HREADYOUT_SI, HRESP_SI;
  logic [1:0]    HTRANS_S;
  logic [2:0]    HSIZE_S;
  logic [AW-1:0] HADDR_S;
  logic [31:0]   HWDATA_S, HRDATA_SI;

  // Each master's bus HREADY is the ready the arbiter returns to it.
  assign HREADY_M0 = HREADYOUT_M0;
  assign HREADY_M1 = HREADYOUT_M1;

  ahb_dsram_arbiter #(.AW(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HSEL_M0(HSEL_M0), .HTRANS_M0(HTRANS_M0), .HSIZE_M0(HSIZE_M0), .HWRITE_M0(HWRITE_M0),
    .HADDR_M0(HADDR_M0), .HWDATA_M0(HWDATA_M0), .HREADY_M0(HREADY_M0),
    .HREADYOUT_M0(HREADYOUT_M0), .HRESP_M0(HRESP_M0), .HRDATA_M0(HRDATA_M0),
    .HSEL_M1(HSEL_M1), .HTRANS_M1(HTRANS_M1), .HSIZE_M1(HSIZE_M1), .HWRITE_M1(HWRITE_M1),
    .HADDR_M1(HADDR_M1), .HWDATA_M1(HWDATA_M1), .HREADY_M1(HREADY_M1),
    .HREADYOUT_M1(HREADYOUT_M1), .HRESP_M1(HRESP_M1), .HRDATA_M1(HRDATA_M1),
    .HSEL_S(HSEL_S), .HTRANS_S(HTRANS_S), .HSIZE_S(HSIZE_S), .HWRITE_S(HWRITE_S),
    .HADDR_S(HADDR_S), .HWDATA_S(HWDATA_S), .HREADY_S(HREADY_S),
    .HREADYOUT_SI(HREADYOUT_SI), .HRESP_SI(HRESP_SI), .HRDATA_SI(HRDATA_SI)
  );

  typedef struct packed {
    logic        write;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] edata;
    logic        eresp;
  } cmd_t;

  typedef struct packed {
    logic        write;
    logic [31:0] edata;
    logic        eresp;
  } exp_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Master models
  cmd_t cmdq0[$], cmdq1[$];
  exp_t expq0[$], expq1[$];
  cmd_t ap[2], dp[2];
  logic ap_v[2], dp_v[2];

  // Slave model
  logic [31:0] mem [0:1023];
  logic        sl_v, sl_write, sl_err, sl_eph;
  logic [15:0] sl_addr;
  int          sl_ws;
  logic [15:0] ws_addr, err_addr;
  int          ws_num;
  logic [15:0] issues[$];

  function automatic logic [31:0] init_val(input logic [15:0] a);
    return {16'hA5A5, a[15:2], 2'b00};
  endfunction

  task automatic push_cmd(input int n, input logic wr, input logic [15:0] a,
                          input logic [31:0] wd, input logic [31:0] ed, input logic er);
    cmd_t c;
    c = '{write: wr, addr: a, wdata: wd, edata: ed, eresp: er};
    if (n == 0) cmdq0.push_back(c);
    else cmdq1.push_back(c);
  endtask

  task automatic rd(input int n, input logic [15:0] a, input logic [31:0] ed);
    push_cmd(n, 1'b0, a, 32'h0, ed, 1'b0);
  endtask

  task automatic drive();
    exp_t e;
    if (sl_v) begin
      if (sl_ws > 0) begin
        HREADYOUT_SI = 1'b0; HRESP_SI = 1'b0; sl_ws--;
      end else if (sl_err) begin
        HRESP_SI = 1'b1; HREADYOUT_SI = sl_eph; sl_eph = 1'b1;
      end else begin
        HREADYOUT_SI = 1'b1; HRESP_SI = 1'b0;
      end
      HRDATA_SI = sl_write ? 32'h0 : mem[sl_addr[11:2]];
    end else begin
      HREADYOUT_SI = 1'b1; HRESP_SI = 1'b0; HRDATA_SI = 32'h0;
    end
    for (int n = 0; n < 2; n++) begin
      if (!ap_v[n] && ((n == 0) ? cmdq0.size() : cmdq1.size()) > 0) begin
        ap[n] = (n == 0) ? cmdq0.pop_front() : cmdq1.pop_front();
        ap_v[n] = 1'b1;
        e = '{write: ap[n].write, edata: ap[n].edata, eresp: ap[n].eresp};
        if (n == 0) expq0.push_back(e);
        else expq1.push_back(e);
      end
    end
    HSEL_M0 = ap_v[0]; HTRANS_M0 = ap_v[0] ? 2'b10 : 2'b00; HSIZE_M0 = 3'd2;
    HWRITE_M0 = ap_v[0] & ap[0].write; HADDR_M0 = ap_v[0] ? ap[0].addr : 16'h0;
    HWDATA_M0 = (dp_v[0] && dp[0].write) ? dp[0].wdata : 32'h0;
    HSEL_M1 = ap_v[1]; HTRANS_M1 = ap_v[1] ? 2'b10 : 2'b00; HSIZE_M1 = 3'd2;
    HWRITE_M1 = ap_v[1] & ap[1].write; HADDR_M1 = ap_v[1] ? ap[1].addr : 16'h0;
    HWDATA_M1 = (dp_v[1] && dp[1].write) ? dp[1].wdata : 32'h0;
  endtask

  task automatic complete(input int n, input logic [31:0] rdata, input logic resp);
    exp_t e;
    if (((n == 0) ? expq0.size() : expq1.size()) == 0) begin
      chk($sformatf("m%0d_sb_underflow", n), 32'd0, 32'd1);
    end else begin
      e = (n == 0) ? expq0.pop_front() : expq1.pop_front();
      chk($sformatf("m%0d_resp", n), {31'd0, resp}, {31'd0, e.eresp});
      if (!e.write && !e.eresp) chk($sformatf("m%0d_rdata", n), rdata, e.edata);
    end
  endtask

  task automatic monitor();
    if (sl_v && HREADYOUT_SI) begin
      if (sl_write) mem[sl_addr[11:2]] = HWDATA_S;
      sl_v = 1'b0;
    end
    if (HREADYOUT_SI && HSEL_S && HTRANS_S[1]) begin
      sl_v = 1'b1; sl_addr = HADDR_S; sl_write = HWRITE_S;
      sl_ws = (HADDR_S == ws_addr) ? ws_num : 0;
      sl_err = (HADDR_S == err_addr); sl_eph = 1'b0;
      issues.push_back(HADDR_S);
    end
    if (dp_v[0] && HREADYOUT_M0) begin complete(0, HRDATA_M0, HRESP_M0); dp_v[0] = 1'b0; end
    if (ap_v[0] && HREADY_M0) begin dp[0] = ap[0]; dp_v[0] = 1'b1; ap_v[0] = 1'b0; end
    if (dp_v[1] && HREADYOUT_M1) begin complete(1, HRDATA_M1, HRESP_M1); dp_v[1] = 1'b0; end
    if (ap_v[1] && HREADY_M1) begin dp[1] = ap[1]; dp_v[1] = 1'b1; ap_v[1] = 1'b0; end
  endtask

  task automatic tick();
    @(posedge HCLK); #1;
    drive();
    @(negedge HCLK);
    monitor();
  endtask

  function automatic logic busy();
    return ap_v[0] | ap_v[1] | dp_v[0] | dp_v[1] | sl_v |
           (cmdq0.size() > 0) | (cmdq1.size() > 0) | (expq0.size() > 0) | (expq1.size() > 0);
  endfunction

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (busy() && k < 200) begin tick(); k++; end
    chk({tag, "_drained"}, {31'd0, busy()}, 32'd0);
  endtask

  task automatic clear_models();
    ap_v[0] = 1'b0; ap_v[1] = 1'b0; dp_v[0] = 1'b0; dp_v[1] = 1'b0; sl_v = 1'b0;
    cmdq0.delete(); cmdq1.delete(); expq0.delete(); expq1.delete(); issues.delete();
  endtask

  logic [15:0] exp_issue[$];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = init_val(16'(i * 4));
    mem[4] = 32'hCAFE0001;
    ws_addr = 16'hFFFF; err_addr = 16'hFFFF; ws_num = 0;
    sl_ws = 0; sl_err = 1'b0; sl_eph = 1'b0; sl_write = 1'b0; sl_addr = 16'h0;
    clear_models();
    HRESETn = 1'b0;
    drive();
    // A live M0 request with write data present must not reach the slave during reset.
    HSEL_M0 = 1'b1; HTRANS_M0 = 2'b10; HADDR_M0 = 16'h1234; HWDATA_M0 = 32'hDEADBEEF;
    @(posedge HCLK); #1;
    chk("rst_hsel_s", {31'd0, HSEL_S}, 32'd0);
    chk("rst_htrans_s", {30'd0, HTRANS_S}, 32'd0);
    chk("rst_haddr_s", {16'd0, HADDR_S}, 32'd0);
    chk("rst_hwdata_s", HWDATA_S, 32'd0);
    chk("rst_hreadyout_m0", {31'd0, HREADYOUT_M0}, 32'd1);
    chk("rst_hreadyout_m1", {31'd0, HREADYOUT_M1}, 32'd1);
    chk("rst_hresp_m0", {31'd0, HRESP_M0}, 32'd0);
    chk("rst_hrdata_m1", HRDATA_M1, 32'd0);
    drive();
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Single uncontended read
    rd(0, 16'h0010, 32'hCAFE0001);
    tick();
    chk("t1_htrans_s", {30'd0, HTRANS_S}, 32'd2);
    chk("t1_haddr_s", {16'd0, HADDR_S}, 32'h0010);
    tick();
    chk("t1_hreadyout_m1", {31'd0, HREADYOUT_M1}, 32'd1);
    chk("t1_hrdata_m1", HRDATA_M1, 32'd0);
    drain("t1");

    // Simultaneous requests: M0 write wins, M1 read is held one cycle
    push_cmd(0, 1'b1, 16'h0100, 32'h11223344, 32'h0, 1'b0);
    rd(1, 16'h0200, init_val(16'h0200));
    tick();
    chk("t2_c0_haddr_s", {16'd0, HADDR_S}, 32'h0100);
    chk("t2_c0_hwrite_s", {31'd0, HWRITE_S}, 32'd1);
    tick();
    chk("t2_c1_haddr_s", {16'd0, HADDR_S}, 32'h0200);
    chk("t2_c1_htrans_s", {30'd0, HTRANS_S}, 32'd2);
    chk("t2_c1_hreadyout_m1", {31'd0, HREADYOUT_M1}, 32'd0);
    chk("t2_c1_hwdata_s", HWDATA_S, 32'h11223344);
    tick();
    chk("t2_c2_hreadyout_m1", {31'd0, HREADYOUT_M1}, 32'd1);
    drain("t2");
    rd(0, 16'h0100, 32'h11223344);
    drain("t2_readback");

    // Slave wait states during an M0 data phase while M1 requests
    ws_addr = 16'h0020; ws_num = 2; issues.delete();
    rd(0, 16'h0020, init_val(16'h0020));
    tick();
    rd(1, 16'h0204, init_val(16'h0204));
    tick();
    chk("t3_c1_hreadyout_m0", {31'd0, HREADYOUT_M0}, 32'd0);
    tick();
    chk("t3_c2_hreadyout_m1", {31'd0, HREADYOUT_M1}, 32'd0);
    chk("t3_c2_issues", issues.size(), 32'd1);
    tick();
    chk("t3_c3_issues", issues.size(), 32'd2);
    chk("t3_c3_haddr_s", {16'd0, HADDR_S}, 32'h0204);
    chk("t3_c3_hrdata_m1", HRDATA_M1, 32'd0);
    tick();
    chk("t3_c4_hrdata_m0", HRDATA_M0, 32'd0);
    drain("t3");
    ws_addr = 16'hFFFF;

    // Two-cycle ERROR response to M1
    err_addr = 16'h0300;
    push_cmd(1, 1'b0, 16'h0300, 32'h0, 32'h0, 1'b1);
    tick();
    tick();
    chk("t4_e1_hresp_m1", {31'd0, HRESP_M1}, 32'd1);
    chk("t4_e1_hreadyout_m1", {31'd0, HREADYOUT_M1}, 32'd0);
    chk("t4_e1_hresp_m0", {31'd0, HRESP_M0}, 32'd0);
    chk("t4_e1_hreadyout_m0", {31'd0, HREADYOUT_M0}, 32'd1);
    tick();
    chk("t4_e2_hresp_m1", {31'd0, HRESP_M1}, 32'd1);
    chk("t4_e2_hreadyout_m1", {31'd0, HREADYOUT_M1}, 32'd1);
    chk("t4_e2_hresp_m0", {31'd0, HRESP_M0}, 32'd0);
    drain("t4");
    err_addr = 16'hFFFF;

    // Continuous traffic from both masters: grant order
    issues.delete();
    exp_issue.delete();
    for (int i = 0; i < 6; i++) begin
      rd(0, 16'(16'h0400 + 4 * i), init_val(16'(16'h0400 + 4 * i)));
      rd(1, 16'(16'h0500 + 4 * i), init_val(16'(16'h0500 + 4 * i)));
    end
`ifdef AHB_DSRAM_ARB_RR_EN
    for (int i = 0; i < 6; i++) begin
      exp_issue.push_back(16'(16'h0400 + 4 * i));
      exp_issue.push_back(16'(16'h0500 + 4 * i));
    end
`else
    for (int i = 0; i < 6; i++) exp_issue.push_back(16'(16'h0400 + 4 * i));
    for (int i = 0; i < 6; i++) exp_issue.push_back(16'(16'h0500 + 4 * i));
    repeat (5) tick();
    chk("t5_m1_starved", {31'd0, HREADYOUT_M1}, 32'd0);
`endif
    drain("t5");
    chk("t5_issue_count", issues.size(), 32'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < issues.size()) chk($sformatf("t5_issue%0d", i), {16'd0, issues[i]}, {16'd0, exp_issue[i]});
    end

    // Reset while M1 has a pending transfer
    rd(0, 16'h0600, init_val(16'h0600));
    rd(1, 16'h0700, init_val(16'h0700));
    tick();
    chk("t6_c0_haddr_s", {16'd0, HADDR_S}, 32'h0600);
    tick();
    chk("t6_c1_hreadyout_m1", {31'd0, HREADYOUT_M1}, 32'd0);
    HRESETn = 1'b0;
    #1;
    chk("t6_rst_htrans_s", {30'd0, HTRANS_S}, 32'd0);
    chk("t6_rst_hsel_s", {31'd0, HSEL_S}, 32'd0);
    chk("t6_rst_hreadyout_m1", {31'd0, HREADYOUT_M1}, 32'd1);
    clear_models();
    repeat (2) tick();
    HRESETn = 1'b1;
    repeat (4) tick();
    chk("t6_no_issue_after_release", issues.size(), 32'd0);
    chk("t6_hreadyout_m1", {31'd0, HREADYOUT_M1}, 32'd1);
    chk("t6_htrans_s", {30'd0, HTRANS_S}, 32'd0);

    chk("sb_left_m0", expq0.size(), 32'd0);
    chk("sb_left_m1", expq1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ahb_dsram_arbiter.md
# ahb_dsram_arbiter

Two-master AHB-Lite arbiter that sits directly upstream of the data SRAM AHB slave and gives the CPU data port (M0) and the DMA/debug port (M1) shared access to it. Uncontended transfers pass straight through with zero added latency. A transfer that loses arbitration is captured into a per-master hold register, and that master's data phase is stalled until the held transfer completes on the slave. Slave responses and read data are routed back to the master that owns the current data phase.

## Interface
- AW, 16, address width; matches the SRAM slave's HADDR width.

- HCLK  input  1  system bus clock.
- HRESETn  input  1  asynchronous active-low reset.
- HSEL_M0/HSEL_M1  input  1  master n targets the data SRAM.
- HTRANS_M0/HTRANS_M1  input  2  master n transfer type.
- HSIZE_M0/HSIZE_M1  input  3  master n transfer size.
- HWRITE_M0/HWRITE_M1  input  1  master n write.
- HADDR_M0/HADDR_M1  input  AW  master n address.
- HWDATA_M0/HWDATA_M1  input  32  master n write data.
- HREADY_M0/HREADY_M1  input  1  master n's bus HREADY.
- HREADYOUT_M0/HREADYOUT_M1  output  1  ready returned to master n.
- HRESP_M0/HRESP_M1  output  1  response returned to master n.
- HRDATA_M0/HRDATA_M1  output  32  read data returned to master n.
- HSEL_S, HTRANS_S, HSIZE_S, HWRITE_S, HADDR_S, HWDATA_S  output  1/2/3/1/AW/32  to the SRAM slave.
- HREADY_S  output  1  HREADY to the slave; equals HREADYOUT_SI.
- HREADYOUT_SI  input  1  slave ready.
- HRESP_SI  input  1  slave response.
- HRDATA_SI  input  32  slave read data.

## Operation
- Live request n: HSEL_Mn & HTRANS_Mn[1] & HREADY_Mn.
- Candidate n: pend_n, or live request n with no pending transfer on n. Pending transfers always take precedence over that master's live bus.
- Arbitration runs only when HREADYOUT_SI=1. The winner's attributes drive the slave address phase. If the winner is live, it passes through combinationally. If it is pending, it comes from hold register n. With no candidates: HSEL_S=0, HTRANS_S=IDLE, other outputs 0.
- Fixed priority: M0 wins over M1.
- A live request that loses, or arrives while HREADYOUT_SI=0, is captured into hold_n (TRANS forced to NONSEQ, SIZE, WRITE, ADDR) and sets pend_n.
  - pend_n clears when that transfer is issued.
  - Master n sees HREADYOUT_Mn=0 from the capture cycle until the issued transfer's data phase completes.
- Data-phase owner register dp_own ∈ {NONE, M0, M1}. It is updated on HREADYOUT_SI=1 with the winner, or NONE if there is no winner.
- HWDATA_S = HWDATA of dp_own; 0 when dp_own=NONE.
- Owner m: HREADYOUT_Mm=HREADYOUT_SI, HRESP_Mm=HRESP_SI, HRDATA_Mm=HRDATA_SI. The two-cycle ERROR response is forwarded unmodified.
- A master that is neither owner nor pending: HREADYOUT=1, HRESP=0, HRDATA=0.
- BUSY/SEQ from a master are forwarded as received when that master is live. A held SEQ is issued as NONSEQ.

## Timing
- Reset (async): pend_0=pend_1=0, dp_own=NONE, hold regs 0.
- Output values in reset: HREADYOUT_Mn=1, HRESP_Mn=0, HRDATA_Mn=0, HSEL_S=0, HTRANS_S=IDLE, HWDATA_S=0.
- Uncontended transfer: 0 added cycles.
- Losing transfer: issued at the earliest on the next cycle with HREADYOUT_SI=1, so it takes 1 stall cycle minimum.
- Simultaneous capture on one master and issue on the other in the same cycle is legal.
- Both masters pending: resolved by the priority rule, one issue per accepting cycle.
- Reset asserted mid-transfer drops pending and in-flight transfers without any response.

## Configuration
- AHB_DSRAM_ARB_RR_EN defined: round-robin arbitration. A last-grant register, reset to M1, sets priority to the master not granted last. The register updates on every issue.
- AHB_DSRAM_ARB_RR_EN undefined: fixed priority, M0 wins. No last-grant register exists.

## Test plan
- M0 read 0x0010, M1 idle, slave data 0xCAFE0001 → HTRANS_S=NONSEQ with HADDR_S=0x0010 in the same cycle. HRDATA_M0=0xCAFE0001 next cycle. HREADYOUT_M1 stays 1.
- Same cycle: M0 write 0x0100 with data 0x11223344, M1 read 0x0200 (fixed priority) → M0 issued at cycle 0. M1 is captured and issued at cycle 1, with HREADYOUT_M1=0 at cycle 1. HREADYOUT_M1=1 with data at cycle 2. SRAM word 0x0100 = 0x11223344.
- Slave inserts 2 wait states during an M0 data phase while M1 requests 0x0204 → M1 is held. It is issued on the first cycle with HREADYOUT_SI=1, and HRDATA is routed to M1 only.
- Slave returns ERROR to an M1 transfer → HRESP_M1=1 for 2 cycles with HREADYOUT_M1 sequence 0 then 1. M0 outputs are unaffected.
- With AHB_DSRAM_ARB_RR_EN, both masters issue continuous NONSEQ → grants alternate M0, M1, M0, M1. Without the macro, M1 is starved while M0 requests every cycle.
- HRESETn asserted while pend_1=1 → pend cleared, HREADYOUT_M1=1, HTRANS_S=IDLE immediately. No transfer issued after release.
